// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM state encoding
// and requester identifiers.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IF = 2'd1,
      GNT_D  = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and
// data access; data has priority, a starvation counter forces fetch progress.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | no access in flight, arbitrate between d_req and if_req
//   GNT_IF | fetch access held on the memory port until mem_ready
//   GNT_D  | data access held on the memory port until mem_ready
//   RESP   | winner's valid pulse, port idle, no arbitration
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,

   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_valid,

   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata,

   output logic                stall_if,
   output logic                stall_mem
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   arb_state_t state, state_nxt;
   logic       grant_if, grant_d, complete;
   logic       owner;
   logic [3:0] starve_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_d   = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && !(if_req && (starve_cnt == STARVE_LIM))) begin
               state_nxt = GNT_D;
               grant_d   = 1'b1;
            end else if (if_req) begin
               state_nxt = GNT_IF;
               grant_if  = 1'b1;
            end
         end
         GNT_IF, GNT_D: begin
            if (mem_ready) begin
               state_nxt = RESP;
               complete  = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // mem_req comes straight from the state register so reset drops it at once
   assign mem_req   = (state == GNT_IF) || (state == GNT_D);
   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = d_req & ~d_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
         owner      <= REQ_IF;
         starve_cnt <= '0;
         if_valid   <= 1'b0;
         d_valid    <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;

         if (grant_d) begin
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_wstrb;
            owner     <= REQ_D;
            if (if_req && (starve_cnt != STARVE_LIM))
               starve_cnt <= starve_cnt + 4'd1;
         end else if (grant_if) begin
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            owner      <= REQ_IF;
            starve_cnt <= '0;
         end

         if (complete) begin
            if (owner == REQ_D) begin
               d_valid <= 1'b1;
               d_rdata <= mem_we ? '0 : mem_rdata;
            end else begin
               if_valid <= 1'b1;
               if_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        stall_if;
   logic        stall_mem;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        if_req;
      logic        d_req;
      logic        d_we;
      logic        rdy;
      logic [31:0] rdata;
      logic        e_mreq;
      logic [31:0] e_addr;
      logic        e_we;
      logic        e_ifv;
      logic        e_dv;
      logic [31:0] e_rdata;
      logic        e_sif;
      logic        e_smem;
   } vec_t;

   function automatic vec_t mk(logic ir, logic dr, logic dw, logic rdy, logic [31:0] rd,
                               logic emr, logic [31:0] ea, logic ew, logic eiv, logic edv,
                               logic [31:0] erd, logic esi, logic esm);
      vec_t v;
      v.if_req = ir;  v.d_req = dr;   v.d_we = dw;   v.rdy = rdy;   v.rdata = rd;
      v.e_mreq = emr; v.e_addr = ea;  v.e_we = ew;   v.e_ifv = eiv; v.e_dv = edv;
      v.e_rdata = erd; v.e_sif = esi; v.e_smem = esm;
      return v;
   endfunction

   vec_t tbl [11];

   // transaction-level reference model and backing memory
   logic [31:0] marr [128];
   logic        m_busy, m_resp, m_owner_d, m_we, m_ifv, m_dv;
   logic [31:0] m_addr, m_wdata, m_ifdata, m_ddata;
   logic [3:0]  m_wstrb;
   int          m_starve;
   logic        in_access;
   int          wait_left;

   task automatic model_step();
      int idx;
      m_ifv = 1'b0;
      m_dv  = 1'b0;
      if (m_resp) begin
         m_resp = 1'b0;
      end else if (m_busy) begin
         if (mem_ready) begin
            idx    = int'(m_addr[8:2]);
            m_busy = 1'b0;
            m_resp = 1'b1;
            if (m_owner_d) begin
               m_dv    = 1'b1;
               m_ddata = m_we ? 32'h0 : marr[idx];
               if (m_we)
                  for (int b = 0; b < 4; b++)
                     if (m_wstrb[b]) marr[idx][8*b +: 8] = m_wdata[8*b +: 8];
            end else begin
               m_ifv    = 1'b1;
               m_ifdata = marr[idx];
            end
         end
      end else if (d_req && !(if_req && m_starve >= STARVE_MAX)) begin
         m_busy = 1'b1; m_owner_d = 1'b1;
         m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_wstrb = d_wstrb;
         if (if_req) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      end else if (if_req) begin
         m_busy = 1'b1; m_owner_d = 1'b0;
         m_addr = if_addr; m_we = 1'b0; m_wdata = 32'h0; m_wstrb = 4'h0;
         m_starve = 0;
      end
   endtask

   logic [31:0] glog [$];
   logic        prev_mreq;

   initial begin
      rst = 1'b0;
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
      mem_ready = 0; mem_rdata = 0;
      #2;
      chk("reset_mem_req", 32'(mem_req), 0);
      chk("reset_mem_addr", mem_addr, 0);
      chk("reset_if_valid", 32'(if_valid), 0);
      chk("reset_d_valid", 32'(d_valid), 0);
      chk("reset_if_rdata", if_rdata, 0);
      chk("reset_d_rdata", d_rdata, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // directed table: lone fetch zero-wait, store with 3 waits, spurious ready
      tbl[0]  = mk(1,0,0,0,32'h0,        0,32'h0,   0, 0,0,32'h0,  1,0);
      tbl[1]  = mk(1,0,0,1,32'h13,       1,32'h100, 0, 0,0,32'h0,  1,0);
      tbl[2]  = mk(0,0,0,0,32'h0,        0,32'h0,   0, 1,0,32'h13, 0,0);
      tbl[3]  = mk(0,1,1,0,32'h0,        0,32'h0,   0, 0,0,32'h0,  0,1);
      tbl[4]  = mk(0,1,1,0,32'h0,        1,32'h2000,1, 0,0,32'h0,  0,1);
      tbl[5]  = mk(0,1,1,0,32'h0,        1,32'h2000,1, 0,0,32'h0,  0,1);
      tbl[6]  = mk(0,1,1,0,32'h0,        1,32'h2000,1, 0,0,32'h0,  0,1);
      tbl[7]  = mk(0,1,1,1,32'h55AA55AA, 1,32'h2000,1, 0,0,32'h0,  0,1);
      tbl[8]  = mk(0,0,0,0,32'h0,        0,32'h0,   0, 0,1,32'h0,  0,0);
      tbl[9]  = mk(0,0,0,1,32'h12345678, 0,32'h0,   0, 0,0,32'h0,  0,0);
      tbl[10] = mk(0,0,0,0,32'h0,        0,32'h0,   0, 0,0,32'h0,  0,0);
      if_addr = 32'h100; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
      for (int i = 0; i < 11; i++) begin
         if_req = tbl[i].if_req; d_req = tbl[i].d_req; d_we = tbl[i].d_we;
         mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rdata;
         #1;
         chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(tbl[i].e_mreq));
         if (tbl[i].e_mreq) begin
            chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].e_we));
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].e_we ? 32'hDEADBEEF : 32'h0);
            chk($sformatf("v%0d_mem_wstrb", i), 32'(mem_wstrb), tbl[i].e_we ? 32'hF : 32'h0);
         end
         chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(tbl[i].e_ifv));
         chk($sformatf("v%0d_d_valid", i), 32'(d_valid), 32'(tbl[i].e_dv));
         if (tbl[i].e_ifv) chk($sformatf("v%0d_if_rdata", i), if_rdata, tbl[i].e_rdata);
         if (tbl[i].e_dv)  chk($sformatf("v%0d_d_rdata", i), d_rdata, tbl[i].e_rdata);
         chk($sformatf("v%0d_stall_if", i), 32'(stall_if), 32'(tbl[i].e_sif));
         chk($sformatf("v%0d_stall_mem", i), 32'(stall_mem), 32'(tbl[i].e_smem));
         tick();
      end

      // contention: both requesting continuously with zero-wait memory
      if_addr = 32'h10; d_addr = 32'h20; d_we = 1'b0; d_wstrb = 4'h0;
      if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0;
      prev_mreq = 1'b0;
      for (int c = 0; c < 80 && glog.size() < 10; c++) begin
         tick();
         if (mem_req && !prev_mreq) glog.push_back(mem_addr);
         prev_mreq = mem_req;
      end
      chk("contention_grant_count", 32'(glog.size()), 10);
      foreach (glog[i])
         chk($sformatf("contention_grant%0d", i), glog[i],
             ((i % (STARVE_MAX + 1)) == STARVE_MAX) ? 32'h10 : 32'h20);
      if_req = 1'b0; d_req = 1'b0;
      repeat (4) tick();
      mem_ready = 1'b0;

      // requester address change while granted is ignored
      d_addr = 32'h40; d_we = 1'b0; d_req = 1'b1;
      tick();
      chk("hold_addr_t0", mem_addr, 32'h40);
      d_addr = 32'h80;
      tick();
      chk("hold_addr_t1", mem_addr, 32'h40);
      chk("hold_mem_req", 32'(mem_req), 1);
      tick();
      chk("hold_addr_t2", mem_addr, 32'h40);
      mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick();
      chk("hold_d_valid", 32'(d_valid), 1);
      chk("hold_d_rdata", d_rdata, 32'hCAFEF00D);
      d_req = 1'b0; mem_ready = 1'b0;
      tick();
      chk("hold_d_valid_pulse", 32'(d_valid), 0);

      // reset while a store is waiting on memory
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h11223344; d_wstrb = 4'hF;
      tick();
      chk("rst_pre_mem_req", 32'(mem_req), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_async_mem_req", 32'(mem_req), 0);
      mem_ready = 1'b1;
      tick();
      chk("rst_no_d_valid", 32'(d_valid), 0);
      chk("rst_mem_req_held", 32'(mem_req), 0);
      d_req = 1'b0; rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h13;
      tick();
      chk("rst_fetch_mem_req", 32'(mem_req), 1);
      chk("rst_fetch_addr", mem_addr, 32'h100);
      tick();
      chk("rst_fetch_valid", 32'(if_valid), 1);
      chk("rst_fetch_rdata", if_rdata, 32'h13);
      chk("rst_fetch_no_d_valid", 32'(d_valid), 0);
      if_req = 1'b0; mem_ready = 1'b0;
      tick();

      // random traffic against the reference model
      rst = 1'b0;
      if_req = 0; d_req = 0; mem_ready = 0;
      for (int i = 0; i < 128; i++) marr[i] = $urandom;
      m_busy = 0; m_resp = 0; m_owner_d = 0; m_we = 0; m_ifv = 0; m_dv = 0;
      m_addr = 0; m_wdata = 0; m_wstrb = 0; m_ifdata = 0; m_ddata = 0; m_starve = 0;
      in_access = 0; wait_left = 0;
      tick();
      rst = 1'b1;
      tick();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         model_step();
         chk("rnd_mem_req", 32'(mem_req), 32'(m_busy));
         if (m_busy) begin
            chk("rnd_mem_addr", mem_addr, m_addr);
            chk("rnd_mem_we", 32'(mem_we), 32'(m_we));
            chk("rnd_mem_wdata", mem_wdata, m_wdata);
            chk("rnd_mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
         end
         chk("rnd_if_valid", 32'(if_valid), 32'(m_ifv));
         chk("rnd_d_valid", 32'(d_valid), 32'(m_dv));
         if (m_ifv) chk("rnd_if_rdata", if_rdata, m_ifdata);
         if (m_dv)  chk("rnd_d_rdata", d_rdata, m_ddata);

         if (!if_req || if_valid) begin
            if ($urandom_range(0, 2) == 0) begin
               if_req  = 1'b1;
               if_addr = {23'h0, 7'($urandom_range(0, 63)), 2'b00};
            end else if_req = 1'b0;
         end
         if (!d_req || d_valid) begin
            if ($urandom_range(0, 2) == 0) begin
               d_req   = 1'b1;
               d_we    = 1'($urandom_range(0, 1));
               d_addr  = {23'h0, 7'($urandom_range(64, 127)), 2'b00};
               d_wdata = $urandom;
               d_wstrb = 4'($urandom_range(0, 15));
            end else d_req = 1'b0;
         end
         if (mem_req) begin
            if (!in_access) begin
               in_access = 1'b1;
               wait_left = $urandom_range(0, 3);
            end
            if (wait_left == 0) begin
               mem_ready = 1'b1;
               mem_rdata = mem_we ? $urandom : marr[int'(mem_addr[8:2])];
               in_access = 1'b0;
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom;
               wait_left--;
            end
         end else begin
            in_access = 1'b0;
            mem_ready = ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
         end
         #1;
         chk("rnd_stall_if", 32'(stall_if), 32'(if_req & ~m_ifv));
         chk("rnd_stall_mem", 32'(stall_mem), 32'(d_req & ~m_dv));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
